n64adv2_hdmi_clksw_seq: RTL and testbench

//  Glitch-safe sequencer for the HDMI pixel-clock mux (altclkctrl main/sub select) in clock/reset housekeeping.

---
 rtl/n64adv2_hdmi_clksw_seq_pkg.sv | 33 +++
 rtl/n64adv2_sync_bus.sv | 29 ++
 rtl/n64adv2_hdmi_clksw_seq.sv | 170 +++++++++++++++++
 tb/tb_n64adv2_hdmi_clksw_seq.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/n64adv2_hdmi_clksw_seq_pkg.sv
// Shared definitions for the HDMI pixel-clock switch sequencer.
//   - hk_clksw_state_e : sequencer state encoding (HK_CLKSW_*)
//   - HK_CLKSW_*       : default wait/sync constants
//   - hk_max4()        : sizing helper for the shared down-counter
package n64adv2_hdmi_clksw_seq_pkg;

  typedef enum logic [2:0] {
    HK_CLKSW_INIT       = 3'd0,
    HK_CLKSW_IDLE       = 3'd1,
    HK_CLKSW_DEBOUNCE   = 3'd2,
    HK_CLKSW_ASSERT_RST = 3'd3,
    HK_CLKSW_SWITCH     = 3'd4,
    HK_CLKSW_REQ_CFG    = 3'd5,
    HK_CLKSW_ACK_LOW    = 3'd6,
    HK_CLKSW_RELEASE    = 3'd7
  } hk_clksw_state_e;

  localparam int HK_CLKSW_SYNC_STAGES  = 2;
  localparam int HK_CLKSW_DEBOUNCE_LEN = 16;
  localparam int HK_CLKSW_RST_WAIT     = 8;
  localparam int HK_CLKSW_SWITCH_WAIT  = 32;
  localparam int HK_CLKSW_ACK_TIMEOUT  = 65535;

  function automatic int hk_max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/n64adv2_sync_bus.sv
// Multi-bit level synchronizer: STAGES flops per bit, async active-low reset to 0.
// Each bit is an independent quasi-static level; no cross-bit coherency is implied.
// Ports:
//   clk   : destination clock
//   rst_n : async active-low reset
//   d     : asynchronous input bus
//   q     : synchronized bus (STAGES cycles of latency)
module n64adv2_sync_bus #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] pipe;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pipe <= '0;
    else        pipe <= {pipe[STAGES-2:0], d};
  end

  assign q = pipe[STAGES-1];

endmodule

// File: rtl/n64adv2_hdmi_clksw_seq.sv
// Glitch-safe sequencer for the HDMI pixel-clock mux.
// Holds the HDMI domain in reset, flips the mux select, asks the NIOS to reload
// the transmitter timing (4-phase req/ack), then releases the reset.
// Ports:
//   SYS_CLK_i        : 60 MHz system clock
//   nSRST_i          : async active-low reset
//   lowlatencymode   : async, low latency mode enable
//   N64_interlaced   : async, N64 interlaced flag
//   HDMI_cfg_done_i  : async, HDMI transmitter configured
//   cfg_ack_i        : NIOS re-config ack, level in SYS_CLK_i domain
//   HDMI_CLK_sel_o   : mux select (1 = sub clock, 0 = main)
//   HDMI_nRST_hold_o : 0 forces the HDMI domain into reset
//   cfg_req_o        : request NIOS timing reload
//   busy_o           : sequence in progress
//   timeout_o        : sticky ack-timeout flag, cleared only by nSRST_i
module n64adv2_hdmi_clksw_seq
  import n64adv2_hdmi_clksw_seq_pkg::*;
#(
  parameter int SYNC_STAGES  = HK_CLKSW_SYNC_STAGES,
  parameter int DEBOUNCE_LEN = HK_CLKSW_DEBOUNCE_LEN,
  parameter int RST_WAIT     = HK_CLKSW_RST_WAIT,
  parameter int SWITCH_WAIT  = HK_CLKSW_SWITCH_WAIT,
  parameter int ACK_TIMEOUT  = HK_CLKSW_ACK_TIMEOUT
) (
  input  logic SYS_CLK_i,
  input  logic nSRST_i,
  input  logic lowlatencymode,
  input  logic N64_interlaced,
  input  logic HDMI_cfg_done_i,
  input  logic cfg_ack_i,
  output logic HDMI_CLK_sel_o,
  output logic HDMI_nRST_hold_o,
  output logic cfg_req_o,
  output logic busy_o,
  output logic timeout_o
);

  localparam int CNT_MAX = hk_max4(DEBOUNCE_LEN, RST_WAIT, SWITCH_WAIT, ACK_TIMEOUT);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // Each load value makes its state last exactly the named number of cycles,
  // except DEBOUNCE which also spends its entry cycle before counting stability.
  localparam logic [CNT_W-1:0] DB_LOAD = CNT_W'(DEBOUNCE_LEN);
  localparam logic [CNT_W-1:0] RW_LOAD = CNT_W'(RST_WAIT - 1);
  localparam logic [CNT_W-1:0] SW_LOAD = CNT_W'((SWITCH_WAIT > 0) ? SWITCH_WAIT - 1 : 0);
  localparam logic [CNT_W-1:0] AT_LOAD = CNT_W'(ACK_TIMEOUT - 1);

  logic [2:0] async_in;
  logic [2:0] sync_out;
  logic       target;
  logic       cfg_done;

  assign async_in = {HDMI_cfg_done_i, N64_interlaced, lowlatencymode};

  n64adv2_sync_bus #(
    .STAGES(SYNC_STAGES),
    .WIDTH (3)
  ) u_sync (
    .clk  (SYS_CLK_i),
    .rst_n(nSRST_i),
    .d    (async_in),
    .q    (sync_out)
  );

  assign target   = sync_out[0] & sync_out[1];
  assign cfg_done = sync_out[2];

  hk_clksw_state_e  state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge SYS_CLK_i or negedge nSRST_i) begin
    if (!nSRST_i) begin
      state            <= HK_CLKSW_INIT;
      cnt              <= '0;
      HDMI_CLK_sel_o   <= 1'b0;
      HDMI_nRST_hold_o <= 1'b0;
      cfg_req_o        <= 1'b0;
      busy_o           <= 1'b1;
      timeout_o        <= 1'b0;
    end else if (state != HK_CLKSW_INIT && !cfg_done) begin
      // Transmitter lost its configuration: park in reset until it is back.
      // The select and the sticky timeout are deliberately kept.
      state            <= HK_CLKSW_INIT;
      cnt              <= '0;
      HDMI_nRST_hold_o <= 1'b0;
      cfg_req_o        <= 1'b0;
      busy_o           <= 1'b1;
    end else begin
      unique case (state)
        HK_CLKSW_INIT: begin
          if (cfg_done) begin
            state          <= HK_CLKSW_SWITCH;
            HDMI_CLK_sel_o <= target;
            cnt            <= SW_LOAD;
          end
        end
        HK_CLKSW_IDLE: begin
          if (target != HDMI_CLK_sel_o) begin
            state  <= HK_CLKSW_DEBOUNCE;
            busy_o <= 1'b1;
            cnt    <= DB_LOAD;
          end
        end
        HK_CLKSW_DEBOUNCE: begin
          // target is one bit, so any toggle lands back on sel: abort and
          // re-enter from IDLE, which restarts the stability count.
          if (target == HDMI_CLK_sel_o) begin
            state  <= HK_CLKSW_IDLE;
            busy_o <= 1'b0;
            cnt    <= '0;
          end else if (cnt == '0) begin
            state            <= HK_CLKSW_ASSERT_RST;
            HDMI_nRST_hold_o <= 1'b0;
            cnt              <= RW_LOAD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HK_CLKSW_ASSERT_RST: begin
          if (cnt == '0) begin
            state          <= HK_CLKSW_SWITCH;
            HDMI_CLK_sel_o <= target;
            cnt            <= SW_LOAD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HK_CLKSW_SWITCH: begin
          if (cnt == '0) begin
            state     <= HK_CLKSW_REQ_CFG;
            cfg_req_o <= 1'b1;
            cnt       <= AT_LOAD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HK_CLKSW_REQ_CFG: begin
          // Level-sensitive: an ack already high on entry is accepted.
          if (cfg_ack_i) begin
            state     <= HK_CLKSW_ACK_LOW;
            cfg_req_o <= 1'b0;
            cnt       <= '0;
          end else if (cnt == '0) begin
            state            <= HK_CLKSW_RELEASE;
            cfg_req_o        <= 1'b0;
            HDMI_nRST_hold_o <= 1'b1;
            timeout_o        <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HK_CLKSW_ACK_LOW: begin
          if (!cfg_ack_i) begin
            state            <= HK_CLKSW_RELEASE;
            HDMI_nRST_hold_o <= 1'b1;
          end
        end
        HK_CLKSW_RELEASE: begin
          state  <= HK_CLKSW_IDLE;
          busy_o <= 1'b0;
        end
        default: begin
          state <= HK_CLKSW_INIT;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_n64adv2_hdmi_clksw_seq.sv
module tb_n64adv2_hdmi_clksw_seq;

  localparam int SYNC_STAGES  = 2;
  localparam int DEBOUNCE_LEN = 16;
  localparam int RST_WAIT     = 8;
  localparam int SWITCH_WAIT  = 32;
  localparam int ACK_TIMEOUT  = 100;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic ll    = 1'b0;
  logic il    = 1'b0;
  logic done  = 1'b0;
  logic ack   = 1'b0;
  logic sel, hold, req, busy, tmo;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  n64adv2_hdmi_clksw_seq #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEBOUNCE_LEN(DEBOUNCE_LEN),
    .RST_WAIT    (RST_WAIT),
    .SWITCH_WAIT (SWITCH_WAIT),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .SYS_CLK_i       (clk),
    .nSRST_i         (rst_n),
    .lowlatencymode  (ll),
    .N64_interlaced  (il),
    .HDMI_cfg_done_i (done),
    .cfg_ack_i       (ack),
    .HDMI_CLK_sel_o  (sel),
    .HDMI_nRST_hold_o(hold),
    .cfg_req_o       (req),
    .busy_o          (busy),
    .timeout_o       (tmo)
  );

  // ---------------------------------------------------------------------
  // Reference model: phases with absolute deadlines, inputs delayed through
  // a history queue to mimic the synchronizer latency.
  // ---------------------------------------------------------------------
  typedef enum {P_BOOT, P_STEADY, P_FILTER, P_RESET_HOLD, P_SETTLE,
                P_REQUEST, P_WAIT_DROP, P_RELEASE} phase_e;

  phase_e     ph      = P_BOOT;
  logic       m_sel   = 1'b0;
  logic       m_tmo   = 1'b0;
  int         cyc     = 0;
  int         end_cyc = 0;
  logic [2:0] hist[$];
  logic [2:0] seen;
  logic       s_tgt, s_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph      = P_BOOT;
      m_sel   = 1'b0;
      m_tmo   = 1'b0;
      cyc     = 0;
      end_cyc = 0;
      hist.delete();
    end else begin
      hist.push_back({done, il, ll});
      if (hist.size() > SYNC_STAGES) seen = hist.pop_front();
      else                           seen = 3'b000;
      s_tgt  = seen[0] & seen[1];
      s_done = seen[2];
      cyc++;
      if (ph != P_BOOT && !s_done) begin
        ph = P_BOOT;
      end else begin
        case (ph)
          P_BOOT:       if (s_done) begin m_sel = s_tgt; ph = P_SETTLE; end_cyc = cyc + SWITCH_WAIT; end
          P_STEADY:     if (s_tgt != m_sel) begin ph = P_FILTER; end_cyc = cyc + DEBOUNCE_LEN + 1; end
          P_FILTER:     if (s_tgt == m_sel) ph = P_STEADY;
                        else if (cyc == end_cyc) begin ph = P_RESET_HOLD; end_cyc = cyc + RST_WAIT; end
          P_RESET_HOLD: if (cyc == end_cyc) begin m_sel = s_tgt; ph = P_SETTLE; end_cyc = cyc + SWITCH_WAIT; end
          P_SETTLE:     if (cyc == end_cyc) begin ph = P_REQUEST; end_cyc = cyc + ACK_TIMEOUT; end
          P_REQUEST:    if (ack) ph = P_WAIT_DROP;
                        else if (cyc == end_cyc) begin m_tmo = 1'b1; ph = P_RELEASE; end
          P_WAIT_DROP:  if (!ack) ph = P_RELEASE;
          P_RELEASE:    ph = P_STEADY;
          default:      ph = P_BOOT;
        endcase
      end
    end
  end

  function automatic logic [4:0] model_vec();
    logic m_hold;
    m_hold = (ph == P_STEADY) || (ph == P_FILTER) || (ph == P_RELEASE);
    return {m_sel, m_hold, ph == P_REQUEST, ph != P_STEADY, m_tmo};
  endfunction

  function automatic logic [4:0] dut_vec();
    return {sel, hold, req, busy, tmo};
  endfunction

  // ---------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------
  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: sel/hold/req/busy/tmo got %b want %b", name, $time, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0d want %0d", name, $time, act, exp);
    end
  endtask

  // Advance n clocks, comparing DUT against the model on every falling edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("model", dut_vec(), model_vec());
    end
  endtask

  task automatic expect_after(input int n, input string name, input logic [4:0] exp);
    step(n);
    check(name, dut_vec(), exp);
  endtask

  // Async reset asserted between edges must force reset values at once.
  task automatic pulse_reset(input string name);
    #2 rst_n = 1'b0;
    #1 check(name, dut_vec(), 5'b00010);
    @(negedge clk);
    check({name, "_held"}, dut_vec(), 5'b00010);
    rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------
  typedef struct {
    logic       ll, il, done, ack;
    int         n;
    logic [4:0] exp;   // {sel, hold, req, busy, tmo}
    string      name;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic a, input logic b, input logic c, input logic d,
                              input int n, input logic [4:0] e, input string s);
    vec_t v;
    v.ll = a; v.il = b; v.done = c; v.ack = d; v.n = n; v.exp = e; v.name = s;
    return v;
  endfunction

  initial begin
    // Power-up: cfg_done late, target 0, ack after 5 cycles of request.
    tbl.push_back(mk(0, 0, 0, 0, 10, 5'b00010, "init_wait"));
    tbl.push_back(mk(0, 0, 1, 0, 34, 5'b00010, "t1_switch"));
    tbl.push_back(mk(0, 0, 1, 0,  1, 5'b00110, "t1_req"));
    tbl.push_back(mk(0, 0, 1, 0,  5, 5'b00110, "t1_req_hold"));
    tbl.push_back(mk(0, 0, 1, 1,  1, 5'b00010, "t1_ack"));
    tbl.push_back(mk(0, 0, 1, 0,  1, 5'b01010, "t1_release"));
    tbl.push_back(mk(0, 0, 1, 0,  1, 5'b01000, "t1_idle"));
    // Target 0->1: hold falls DEBOUNCE_LEN+2 after sync, sel RST_WAIT later,
    // request SWITCH_WAIT after that.
    tbl.push_back(mk(1, 1, 1, 0,  2, 5'b01000, "t2_sync"));
    tbl.push_back(mk(1, 1, 1, 0,  1, 5'b01010, "t2_debounce"));
    tbl.push_back(mk(1, 1, 1, 0, 16, 5'b01010, "t2_deb_end"));
    tbl.push_back(mk(1, 1, 1, 0,  1, 5'b00010, "t2_hold_fall"));
    tbl.push_back(mk(1, 1, 1, 0,  7, 5'b00010, "t2_pre_sel"));
    tbl.push_back(mk(1, 1, 1, 0,  1, 5'b10010, "t2_sel"));
    tbl.push_back(mk(1, 1, 1, 0, 31, 5'b10010, "t2_settle"));
    tbl.push_back(mk(1, 1, 1, 0,  1, 5'b10110, "t2_req"));
    tbl.push_back(mk(1, 1, 1, 1,  1, 5'b10010, "t2_ack"));
    tbl.push_back(mk(1, 1, 1, 0,  1, 5'b11010, "t2_release"));
    tbl.push_back(mk(1, 1, 1, 0,  1, 5'b11000, "t2_idle"));

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset", dut_vec(), 5'b00010);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      ll = tbl[i].ll; il = tbl[i].il; done = tbl[i].done; ack = tbl[i].ack;
      step(tbl[i].n);
      check(tbl[i].name, dut_vec(), tbl[i].exp);
    end

    // Test 3: target chatter shorter than the debounce window never switches.
    for (int k = 0; k < 12; k++) begin
      il = (k % 2 == 0) ? 1'b0 : 1'b1;
      for (int j = 0; j < 10; j++) begin
        step(1);
        check_int("t3_sel_hold", int'({sel, hold}), 3);
      end
    end
    step(5);

    // Test 4: request never acknowledged.
    begin
      int req_cycles;
      req_cycles = 0;
      il = 1'b0;
      for (int i = 0; i < 200; i++) begin
        step(1);
        if (req) req_cycles++;
      end
      check_int("t4_req_len", req_cycles, ACK_TIMEOUT);
      check("t4_end", dut_vec(), 5'b01001);
    end

    // Test 5: cfg_done drops during SWITCH, then returns.
    il = 1'b1;
    expect_after(40, "t5_in_switch", 5'b10011);
    done = 1'b0;
    expect_after(3, "t5_init", 5'b10011);
    expect_after(40, "t5_parked", 5'b10011);
    done = 1'b1;
    expect_after(34, "t5_resettle", 5'b10011);
    expect_after(1, "t5_req", 5'b10111);
    ack = 1'b1;
    expect_after(1, "t5_ack", 5'b10011);
    ack = 1'b0;
    expect_after(1, "t5_release", 5'b11011);
    expect_after(1, "t5_idle", 5'b11001);

    // Test 6: target flips back during SWITCH; sequence completes, then reverts.
    il = 1'b0;
    expect_after(40, "t6_switch_sel0", 5'b00011);
    il = 1'b1;
    expect_after(20, "t6_req", 5'b00111);
    ack = 1'b1;
    expect_after(1, "t6_ack", 5'b00011);
    ack = 1'b0;
    expect_after(1, "t6_release", 5'b01011);
    expect_after(1, "t6_idle", 5'b01001);
    expect_after(1, "t6_redebounce", 5'b01011);
    expect_after(24, "t6_pre_sel", 5'b00011);
    expect_after(1, "t6_sel1", 5'b10011);
    expect_after(31, "t6_settle", 5'b10011);
    expect_after(1, "t6_req2", 5'b10111);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    expect_after(2, "t6_done", 5'b11001);

    // Async reset in the middle of a sequence.
    il = 1'b0;
    step(25);
    pulse_reset("mid_reset");
    step(5);

    // Randomized segments checked against the model.
    for (int seg = 0; seg < 120; seg++) begin
      ll   = 1'($urandom_range(0, 3) != 0);
      il   = 1'($urandom_range(0, 1));
      done = 1'($urandom_range(0, 15) != 0);
      ack  = 1'($urandom_range(0, 1));
      step($urandom_range(1, 60));
      if ($urandom_range(0, 39) == 0) pulse_reset("rand_reset");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
